phys_free_list: RTL and testbench

- Circular FIFO of unallocated physical register tags.
- Sits directly upstream of the register alias table in the rename stage. It supplies the next physical tag for each renamed destination write and accepts tags returned at retirement.
- Replaces a free-running next-tag counter, so tags are reused only after they are explicitly released.

---
 rtl/phys_free_list.sv | 95 +++++++++
 tb/tb_phys_free_list.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Circular FIFO of unallocated physical register tags for the rename stage.
// The head tag is presented combinationally; retired tags are appended at the tail.
module phys_free_list #(
   parameter int PHYS_REGS = 32,
   parameter int TAG_W     = 5,
   parameter int ARCH_REGS = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc_req,
   output logic             alloc_valid,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             free_req,
   input  logic [TAG_W-1:0] free_tag,
   output logic [TAG_W:0]   free_count,
   output logic             empty,
   output logic             full,
   output logic             err_underflow,
   output logic             err_overflow
);

   localparam int             INIT_FREE  = PHYS_REGS - ARCH_REGS;
   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(PHYS_REGS);
   localparam logic [TAG_W:0] INIT_COUNT = (TAG_W+1)'(INIT_FREE);
   localparam logic [TAG_W-1:0] INIT_TAIL = TAG_W'(INIT_FREE);

   logic [TAG_W-1:0] entry_reg [PHYS_REGS];
   logic [TAG_W-1:0] head_reg, head_next;
   logic [TAG_W-1:0] tail_reg, tail_next;
   logic [TAG_W:0]   count_reg, count_next;
   logic             err_underflow_reg, err_underflow_next;
   logic             err_overflow_reg, err_overflow_next;
   logic             alloc_ok, free_ok;

   assign empty         = (count_reg == '0);
   assign full          = (count_reg == FULL_COUNT);
   assign free_count    = count_reg;
   assign alloc_valid   = ~empty;
   assign alloc_tag     = entry_reg[head_reg];
   assign err_underflow = err_underflow_reg;
   assign err_overflow  = err_overflow_reg;

   // A release into a full list is still accepted when the head is vacated in the same cycle.
   assign alloc_ok = alloc_req & ~empty;
   assign free_ok  = free_req & (~full | alloc_ok);

   always_comb begin
      head_next          = head_reg;
      tail_next          = tail_reg;
      count_next         = count_reg;
      err_underflow_next = err_underflow_reg | (alloc_req & empty);
      err_overflow_next  = err_overflow_reg | (free_req & ~free_ok);
      if (alloc_ok)
         head_next = head_reg + 1'b1;
      if (free_ok)
         tail_next = tail_reg + 1'b1;
      case ({free_ok, alloc_ok})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_reg          <= '0;
         tail_reg          <= INIT_TAIL;
         count_reg         <= INIT_COUNT;
         err_underflow_reg <= 1'b0;
         err_overflow_reg  <= 1'b0;
      end else begin
         head_reg          <= head_next;
         tail_reg          <= tail_next;
         count_reg         <= count_next;
         err_underflow_reg <= err_underflow_next;
         err_overflow_reg  <= err_overflow_next;
      end
   end

   // Entries past the initially free tags start at zero; they are only read after being written.
   generate
      for (genvar gi = 0; gi < PHYS_REGS; gi++) begin : g_entry
         localparam logic [TAG_W-1:0] INIT_TAG =
            (gi < INIT_FREE) ? TAG_W'(ARCH_REGS + gi) : '0;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               entry_reg[gi] <= INIT_TAG;
            else if (free_ok && (tail_reg == TAG_W'(gi)))
               entry_reg[gi] <= free_tag;
         end
      end
   endgenerate

endmodule

// File: tb/tb_phys_free_list.sv
// Randomized and directed bench for phys_free_list against a queue-based model
// of the free tag pool.
module tb_phys_free_list;

   localparam int PR = 32;
   localparam int TW = 5;
   localparam int AR = 14;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          alloc_req = 1'b0;
   logic          free_req = 1'b0;
   logic [TW-1:0] free_tag = '0;
   logic          alloc_valid;
   logic [TW-1:0] alloc_tag;
   logic [TW:0]   free_count;
   logic          empty, full, err_underflow, err_overflow;

   int total = 0;
   int bad   = 0;
   int txn   = 0;
   int q[$];
   bit m_uf, m_of;

   phys_free_list #(.PHYS_REGS(PR), .TAG_W(TW), .ARCH_REGS(AR)) dut (
      .clk(clk),
      .reset(reset),
      .alloc_req(alloc_req),
      .alloc_valid(alloc_valid),
      .alloc_tag(alloc_tag),
      .free_req(free_req),
      .free_tag(free_tag),
      .free_count(free_count),
      .empty(empty),
      .full(full),
      .err_underflow(err_underflow),
      .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, obs, exp, txn);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = AR; i < PR; i++) q.push_back(i);
      m_uf = 1'b0;
      m_of = 1'b0;
   endtask

   task automatic check_all();
      check("free_count", int'(free_count), q.size());
      check("empty", int'(empty), int'(q.size() == 0));
      check("full", int'(full), int'(q.size() == PR));
      check("alloc_valid", int'(alloc_valid), int'(q.size() != 0));
      check("err_underflow", int'(err_underflow), int'(m_uf));
      check("err_overflow", int'(err_overflow), int'(m_of));
      if (q.size() > 0) check("alloc_tag", int'(alloc_tag), q[0]);
   endtask

   // One clock of stimulus; inputs are applied 1 time unit after the previous edge.
   task automatic cycle(input bit ar, input bit fr, input int ft);
      int n;
      bit a_ok, f_ok;
      alloc_req = ar;
      free_req  = fr;
      free_tag  = ft[TW-1:0];
      n    = q.size();
      a_ok = ar && (n > 0);
      f_ok = fr && ((n < PR) || a_ok);
      if (ar && !a_ok) m_uf = 1'b1;
      if (fr && !f_ok) m_of = 1'b1;
      if (a_ok) void'(q.pop_front());
      if (f_ok) q.push_back(ft % PR);
      @(posedge clk);
      #1;
      alloc_req = 1'b0;
      free_req  = 1'b0;
      txn++;
      $display("txn %0d alloc=%0b free=%0b free_tag=%0d count=%0d head=%0d", txn, ar, fr,
               ft, free_count, alloc_tag);
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int t;
      int pa, pf;

      // 1: reset state
      model_reset();
      #12;
      check_all();
      @(posedge clk);
      #1;
      reset = 1'b1;
      check_all();
      check("rst_alloc_tag", int'(alloc_tag), AR);
      check("rst_count", int'(free_count), PR - AR);

      // 2: drain the list in order, then underflow
      for (int i = 0; i < PR - AR; i++) begin
         check("alloc_seq", int'(alloc_tag), AR + i);
         cycle(1'b1, 1'b0, 0);
      end
      check("drained_empty", int'(empty), 1);
      cycle(1'b1, 1'b0, 0);
      check("underflow_flag", int'(err_underflow), 1);

      // 3: simultaneous alloc and release while empty
      cycle(1'b1, 1'b1, 7);
      check("empty_release_count", int'(free_count), 1);
      check("empty_release_tag", int'(alloc_tag), 7);

      // 4: fill to full, overflow, then alloc+release while full
      do_reset();
      for (int i = 0; i < AR; i++) cycle(1'b0, 1'b1, i);
      check("filled_full", int'(full), 1);
      cycle(1'b0, 1'b1, 20);
      check("overflow_flag", int'(err_overflow), 1);
      cycle(1'b1, 1'b1, 5);
      check("full_swap_count", int'(free_count), PR);
      check("full_swap_tag", int'(alloc_tag), AR + 1);

      // 5: wrap-around with every allocated tag recycled
      do_reset();
      for (int k = 0; k < 40; k++) begin
         check("wrap_order", int'(alloc_tag), AR + (k % (PR - AR)));
         t = q[0];
         cycle(1'b1, 1'b1, t);
      end
      check("wrap_count", int'(free_count), PR - AR);

      // random phases with varied alloc/release bias
      do_reset();
      for (int p = 0; p < 6; p++) begin
         pa = (p % 2 == 0) ? 75 : 25;
         pf = (p % 2 == 0) ? 25 : 80;
         for (int i = 0; i < 60; i++) begin
            cycle($urandom_range(0, 99) < pa, $urandom_range(0, 99) < pf,
                  int'($urandom_range(0, PR - 1)));
         end
      end

      // 6: asynchronous reset mid-stream with a pending release
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0);
      alloc_req = 1'b1;
      free_req  = 1'b1;
      free_tag  = 5'd3;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      check("midrst_tag", int'(alloc_tag), AR);
      check("midrst_count", int'(free_count), PR - AR);
      @(posedge clk);
      #1;
      alloc_req = 1'b0;
      free_req  = 1'b0;
      reset     = 1'b1;
      cycle(1'b0, 1'b0, 0);
      check("midrst_no_release", int'(free_count), PR - AR);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
